// File: rtl/spi_responder.sv
// SPI mode-0 responder: oversamples sck/mosi/cs on the system clock,
// shifts MSB-first, with a one-entry TX holding buffer.
module spi_responder #(
    parameter logic [7:0] DEFAULT_FILL = 8'hFF,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       sck,
    input  logic       mosi,
    input  logic       cs,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_underrun,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_d;
    logic                   cs_d;

    logic sck_s;
    logic cs_s;
    logic mosi_s;
    logic sck_rise;
    logic sck_fall;
    logic cs_fall;
    logic cs_rise;

    logic [3:0] bit_cnt, bit_cnt_n;
    logic       reload, reload_n;
    logic [7:0] tx_sh, tx_sh_n;
    logic [7:0] rx_sh, rx_sh_n;
    logic [7:0] rx_data_n;
    logic       rx_valid_n;
    logic       underrun_n;
    logic       miso_n;

    logic [7:0] tx_buf, tx_buf_n;
    logic       tx_full, tx_full_n;
    logic       tx_accept;
    logic       do_load;
    logic [7:0] load_byte;
    logic [7:0] rx_next;

    // Idle levels chosen so reset never produces a spurious edge.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '1;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_d     <= sck_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_fall  = ~cs_s & cs_d;
    assign cs_rise  = cs_s & ~cs_d;

    assign tx_accept = tx_valid & ~tx_full;
    assign load_byte = tx_full ? tx_buf : DEFAULT_FILL;
    assign rx_next   = {rx_sh[6:0], mosi_s};

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        reload_n   = reload;
        tx_sh_n    = tx_sh;
        rx_sh_n    = rx_sh;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        underrun_n = 1'b0;
        miso_n     = miso;
        do_load    = 1'b0;

        unique case (state)
            IDLE: begin
                miso_n = 1'b1;
                if (cs_fall) begin
                    state_n = SHIFT;
                    do_load = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_n   = IDLE;
                    miso_n    = 1'b1;
                    bit_cnt_n = 4'd0;
                    reload_n  = 1'b0;
                    rx_sh_n   = 8'h00;
                end else if (sck_rise) begin
                    rx_sh_n = rx_next;
                    if (bit_cnt == 4'd7) begin
                        rx_data_n  = rx_next;
                        rx_valid_n = 1'b1;
                        bit_cnt_n  = 4'd0;
                        reload_n   = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end else if (sck_fall) begin
                    if (reload) begin
                        do_load  = 1'b1;
                        reload_n = 1'b0;
                    end else begin
                        tx_sh_n = {tx_sh[6:0], 1'b0};
                        miso_n  = tx_sh[6];
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (do_load) begin
            tx_sh_n    = load_byte;
            miso_n     = load_byte[7];
            bit_cnt_n  = 4'd0;
            underrun_n = ~tx_full;
        end
    end

    // A byte accepted during a load waits for the next load.
    assign tx_full_n = (tx_full & ~do_load) | tx_accept;
    assign tx_buf_n  = tx_accept ? tx_data : tx_buf;

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= 4'd0;
            reload      <= 1'b0;
            tx_sh       <= 8'h00;
            rx_sh       <= 8'h00;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            miso        <= 1'b1;
            tx_buf      <= 8'h00;
            tx_full     <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            reload      <= reload_n;
            tx_sh       <= tx_sh_n;
            rx_sh       <= rx_sh_n;
            rx_data     <= rx_data_n;
            rx_valid    <= rx_valid_n;
            tx_underrun <= underrun_n;
            miso        <= miso_n;
            tx_buf      <= tx_buf_n;
            tx_full     <= tx_full_n;
        end
    end

    assign tx_ready = ~tx_full;
    assign busy     = (state == SHIFT);

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: drives a mode-0 initiator
// and checks miso stream, rx bytes, buffer and pulse behaviour.
module tb_spi_responder;

    localparam int HALF = 5;

    logic       clk_50m = 1'b0;
    logic       rst_n;
    logic       sck;
    logic       mosi;
    logic       cs;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int rxv_cnt  = 0;
    int und_cnt  = 0;

    spi_responder #(
        .DEFAULT_FILL(8'hFF),
        .SYNC_STAGES (2)
    ) dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .sck        (sck),
        .mosi       (mosi),
        .cs         (cs),
        .miso       (miso),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_underrun(tx_underrun),
        .busy       (busy)
    );

    always #10 clk_50m = ~clk_50m;

    always @(negedge clk_50m) begin
        if (rx_valid) rxv_cnt = rxv_cnt + 1;
        if (tx_underrun) und_cnt = und_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    task automatic offer(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        clks(1);
        tx_valid = 1'b0;
    endtask

    task automatic cs_start();
        cs = 1'b0;
        clks(8);
    endtask

    task automatic cs_end();
        cs = 1'b1;
        clks(6);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n,
                            output logic [7:0] got);
        got = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = tx[i];
            clks(HALF);
            got[i] = miso;
            sck = 1'b1;
            clks(HALF);
            sck = 1'b0;
        end
        clks(HALF);
    endtask

    logic [7:0] m;
    logic [7:0] m2;
    int r0;
    int u0;

    initial begin
        rst_n    = 1'b0;
        sck      = 1'b0;
        mosi     = 1'b1;
        cs       = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        clks(3);
        rst_n = 1'b1;
        clks(2);

        check("rst_miso", miso, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_underrun", tx_underrun, 0);
        check("rst_busy", busy, 0);

        // preloaded A5, receive 74
        offer(8'hA5);
        check("t1_ready_low", tx_ready, 0);
        r0 = rxv_cnt;
        u0 = und_cnt;
        cs_start();
        check("t1_ready_back", tx_ready, 1);
        check("t1_busy", busy, 1);
        check("t1_no_underrun", und_cnt - u0, 0);
        spi_bits(8'h74, 8, m);
        check("t1_miso", m, 8'hA5);
        check("t1_rx_data", rx_data, 8'h74);
        check("t1_rxv", rxv_cnt - r0, 1);
        cs_end();
        check("t1_busy_off", busy, 0);
        check("t1_miso_idle", miso, 1);

        // empty buffer, receive 3C
        u0 = und_cnt;
        cs_start();
        check("t2_underrun_csfall", und_cnt - u0, 1);
        spi_bits(8'h3C, 8, m);
        check("t2_miso", m, 8'hFF);
        check("t2_rx_data", rx_data, 8'h3C);
        cs_end();

        // back-to-back with C3 offered during byte 1
        r0 = rxv_cnt;
        cs_start();
        offer(8'hC3);
        spi_bits(8'h11, 8, m);
        check("t3_miso1", m, 8'hFF);
        check("t3_rx1", rx_data, 8'h11);
        spi_bits(8'h22, 8, m2);
        check("t3_miso2", m2, 8'hC3);
        check("t3_rx2", rx_data, 8'h22);
        check("t3_rxv", rxv_cnt - r0, 2);
        cs_end();

        // abort after 5 rises
        offer(8'h5A);
        r0 = rxv_cnt;
        cs_start();
        spi_bits(8'hF0, 5, m);
        check("t4_partial_miso", m[7:3], 5'b01011);
        cs_end();
        check("t4_rxv", rxv_cnt - r0, 0);
        check("t4_rx_data", rx_data, 8'h22);
        check("t4_miso", miso, 1);
        check("t4_busy", busy, 0);
        offer(8'h96);
        cs_start();
        spi_bits(8'h0F, 8, m);
        check("t4_next_miso", m, 8'h96);
        check("t4_next_rx", rx_data, 8'h0F);
        cs_end();

        // reset mid-byte with buffer full
        offer(8'h77);
        cs_start();
        offer(8'h88);
        check("t5_full", tx_ready, 0);
        spi_bits(8'hAA, 3, m);
        rst_n = 1'b0;
        cs    = 1'b1;
        clks(1);
        rst_n = 1'b1;
        check("t5_miso", miso, 1);
        check("t5_tx_ready", tx_ready, 1);
        check("t5_rx_valid", rx_valid, 0);
        check("t5_rx_data", rx_data, 8'h00);
        check("t5_underrun", tx_underrun, 0);
        check("t5_busy", busy, 0);
        clks(6);
        check("t5_stay_idle", busy, 0);

        // sck with cs high; tx_valid held while full
        offer(8'h3E);
        r0 = rxv_cnt;
        tx_data  = 8'h99;
        tx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mosi = i[0];
            sck  = 1'b1;
            clks(HALF);
            sck = 1'b0;
            clks(HALF);
        end
        check("t6_rxv", rxv_cnt - r0, 0);
        check("t6_busy", busy, 0);
        check("t6_miso", miso, 1);
        check("t6_ready", tx_ready, 0);
        tx_valid = 1'b0;
        cs_start();
        spi_bits(8'h00, 8, m);
        check("t6_kept", m, 8'h3E);
        check("t6_rx", rx_data, 8'h00);
        cs_end();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_responder.md
# spi_responder

SPI mode-0 responder (target) that serves as the far end of the team's `spi` initiator. It provides a synthesizable peripheral model for loopback benches and a device-side port for FPGA-to-FPGA links. The block oversamples the external `sck`/`mosi`/`cs` lines on a fast system clock and shifts bytes MSB-first. It hands each received byte to local logic and drives `miso` from a one-entry transmit holding buffer.

## Interface

Parameters:
- `DEFAULT_FILL`, 8'hFF: byte shifted out when the TX buffer is empty at a byte boundary.
- `SYNC_STAGES`, 2: flops in each input synchronizer; minimum 2.

Ports:
- `clk_50m` in 1: system clock; must be at least 8× the `sck` frequency.
- `rst_n` in 1: reset, synchronous, active-low.
- `sck` in 1: SPI clock from the initiator, asynchronous to `clk_50m`, idle low.
- `mosi` in 1: initiator-to-responder data, asynchronous.
- `cs` in 1: chip select, active-low, asynchronous.
- `miso` out 1: responder-to-initiator data.
- `tx_data` in 8: next byte to send.
- `tx_valid` in 1: `tx_data` offered.
- `tx_ready` out 1: TX holding buffer is empty.
- `rx_data` out 8: last complete received byte; held until the next byte completes.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `tx_underrun` out 1: one-cycle pulse when `DEFAULT_FILL` is loaded because the buffer was empty.
- `busy` out 1: high while in SHIFT.

## Operation

- Synchronizers: each of `sck`, `mosi`, `cs` passes through `SYNC_STAGES` flops plus one delay flop for edge detection.
  - `sck_rise` = synced high and delayed low; `sck_fall` is the inverse.
  - `cs_fall` and `cs_rise` are defined the same way.
- TX buffer:
  - Accepts a byte when `tx_valid && tx_ready`, after which `tx_ready` drops.
  - Empties when its contents are loaded into the TX shift register.
  - A load only consumes a byte present at the start of the cycle. A byte accepted in the same cycle as a load waits for the next load; there is no bypass.
- Load event: load TX shift from the buffer if full, otherwise load `DEFAULT_FILL` and pulse `tx_underrun`. Reset `bit_cnt` to 0.
- FSM states: IDLE and SHIFT.
  - IDLE → SHIFT on `cs_fall`; perform a load event; `miso` = bit 7 of the loaded byte.
  - SHIFT, on `sck_rise`: shift synced `mosi` into the RX shift register (LSB in) and increment `bit_cnt`.
    - When `bit_cnt` reaches 8: copy the RX shift register to `rx_data`, pulse `rx_valid`, set `bit_cnt` to 0, and arm `reload`.
  - SHIFT, on `sck_fall`:
    - If `reload` is armed: perform a load event, clear `reload`, and drive bit 7 of the new byte.
    - Otherwise: shift TX left and drive the next bit.
  - SHIFT → IDLE on `cs_rise`, which takes priority over `sck` edges in the same cycle.
    - Discard any partial RX byte; no `rx_valid`.
    - Discard the partial TX byte; the buffer is untouched.
    - `miso` returns to 1.
- `miso` is 1 whenever the FSM is in IDLE.
- `bit_cnt` is 4 bits wide and never exceeds 8.

## Timing

- Reset values: `miso`=1, `tx_ready`=1, `rx_valid`=0, `rx_data`=8'h00, `tx_underrun`=0, `busy`=0, state IDLE, `bit_cnt`=0, `reload`=0.
- Synchronizer reset values: `sck`=0, `cs`=1, `mosi`=1.
- Input-to-edge latency is `SYNC_STAGES`+1 clk cycles.
- `miso` changes on the clk edge after the detected `cs_fall` or `sck_fall`. The initiator must allow at least `SYNC_STAGES`+3 clk cycles between CS falling and the first SCK rise.
- `rx_valid` is high for exactly the one cycle after the 8th detected `sck_rise`.
- `busy` rises the cycle after `cs_fall` is detected and falls the cycle after `cs_rise` is detected.
- Reset asserted mid-byte: all state returns to reset values on that edge, and the buffer is emptied.
- A `sck` rise while `cs` is high is ignored.

## Test plan

- Buffer preloaded with 8'hA5; CS low; initiator sends 8'h74 → `miso` bit stream is 1,0,1,0,0,1,0,1; `rx_data`=8'h74; one `rx_valid` pulse; `tx_ready` returns to 1 at CS-fall load.
- Empty buffer; 1-byte transfer of 8'h3C → `miso` is all ones; `tx_underrun` pulses once at CS fall; `rx_data`=8'h3C.
- Back-to-back bytes 8'h11, 8'h22 with 8'hC3 offered during byte 1 → second byte shifts out 8'hC3; two `rx_valid` pulses, with `rx_data` 8'h11 then 8'h22.
- CS raised after 5 SCK rises → no `rx_valid`; `rx_data` unchanged; `miso`=1; `busy`=0; next transaction starts at bit 7 cleanly.
- `rst_n` low for 1 cycle mid-byte with buffer full → all outputs at reset values the next cycle; `tx_ready`=1.
- SCK toggled with CS high, and `tx_valid` held with `tx_ready`=0 → no `rx_valid`, no shift, and the buffered byte is not overwritten.
